// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline constants and hazard controller state encoding
package pipe_hazard_ctrl_pkg;
  localparam int DW_C = 16;
  localparam int AW_C = 3;
  localparam int CNT_W = 16;
  localparam logic BUBBLE = 1'b0;
  typedef enum logic [1:0] {
    RUN           = 2'd0,
    MEM_WAIT      = 2'd1,
    MEM_WAIT_PEND = 2'd2
  } state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: saturating event counter with synchronous clear
module hazard_perf_cnt
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect controller for the 6-stage pipeline
// HAZ_PERF_CNT_EN adds saturating load-use, redirect and freeze counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DW = DW_C,
  parameter int AW = AW_C
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rr_src_a,
  input  logic          rr_src_a_vld,
  input  logic [AW-1:0] rr_src_b,
  input  logic          rr_src_b_vld,
  input  logic [AW-1:0] ex_dst,
  input  logic          ex_wr_en,
  input  logic          ex_is_load,
  input  logic          ex_br_vld,
  input  logic          ex_br_taken,
  input  logic          ex_spec_taken,
  input  logic [DW-1:0] ex_br_target,
  input  logic [DW-1:0] ex_pc_next,
  input  logic          mem_busy,
  output logic          pc_en,
  output logic          if2id_en,
  output logic          id2rr_en,
  output logic          rr2ex_en,
  output logic          ex2mem_en,
  output logic          mem2wb_en,
  output logic          if2id_flush,
  output logic          id2rr_flush,
  output logic          rr2ex_flush,
  output logic          redir_vld,
  output logic [DW-1:0] redir_pc
`ifdef HAZ_PERF_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_mispred,
  output logic [CNT_W-1:0] cnt_memw
`endif
);
  state_e state_q, state_d;
  logic [DW-1:0] pend_pc_q, pend_pc_d, tgt;
  logic is_run, mispred, lu_haz, freeze, redir_now, redir_pend, stall;
  always_comb begin
    is_run      = state_q != MEM_WAIT && state_q != MEM_WAIT_PEND;
    mispred     = ex_br_vld & (ex_br_taken != ex_spec_taken);
    tgt         = ex_br_taken ? ex_br_target : ex_pc_next;
    lu_haz      = ex_is_load & ex_wr_en & ((rr_src_a_vld & (rr_src_a == ex_dst)) | (rr_src_b_vld & (rr_src_b == ex_dst)));
    freeze      = ~rst & mem_busy;
    redir_now   = ~rst & ~mem_busy & is_run & mispred;
    redir_pend  = ~rst & ~mem_busy & (state_q == MEM_WAIT_PEND);
    stall       = ~rst & ~mem_busy & ~redir_now & (state_q != MEM_WAIT_PEND) & lu_haz;
    pc_en       = ~freeze & ~stall;
    if2id_en    = ~freeze & ~stall;
    id2rr_en    = ~freeze & ~stall;
    rr2ex_en    = ~freeze;
    ex2mem_en   = ~freeze;
    mem2wb_en   = ~freeze;
    redir_vld   = redir_now | redir_pend;
    if2id_flush = redir_vld;
    id2rr_flush = redir_vld;
    rr2ex_flush = redir_vld | stall;
    redir_pc    = redir_pend ? pend_pc_q : redir_now ? tgt : '0;
    // a mispredict that meets a busy memory is parked until the freeze lifts
    state_d     = (rst || !mem_busy) ? RUN : (state_q == MEM_WAIT_PEND || (is_run && mispred)) ? MEM_WAIT_PEND : MEM_WAIT;
    pend_pc_d   = rst ? '0 : (is_run && mem_busy && mispred) ? tgt : pend_pc_q;
  end
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    pend_pc_q <= pend_pc_d;
  end
`ifdef HAZ_PERF_CNT_EN
  hazard_perf_cnt u_cnt_lu (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(stall), .cnt(cnt_lu));
  hazard_perf_cnt u_cnt_mispred (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(redir_vld), .cnt(cnt_mispred));
  hazard_perf_cnt u_cnt_memw (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(freeze), .cnt(cnt_memw));
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, mem_busy, ex_wr_en, ex_is_load, rr_src_a_vld, rr_src_b_vld;
  logic ex_br_vld, ex_br_taken, ex_spec_taken;
  logic [2:0] rr_src_a, rr_src_b, ex_dst;
  logic [15:0] ex_br_target, ex_pc_next, redir_pc;
  logic pc_en, if2id_en, id2rr_en, rr2ex_en, ex2mem_en, mem2wb_en;
  logic if2id_flush, id2rr_flush, rr2ex_flush, redir_vld;
`ifdef HAZ_PERF_CNT_EN
  logic cnt_clr = 1'b0;
  logic [15:0] cnt_lu, cnt_mispred, cnt_memw;
`endif
  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rr_src_a(rr_src_a), .rr_src_a_vld(rr_src_a_vld),
    .rr_src_b(rr_src_b), .rr_src_b_vld(rr_src_b_vld),
    .ex_dst(ex_dst), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_br_vld(ex_br_vld), .ex_br_taken(ex_br_taken), .ex_spec_taken(ex_spec_taken),
    .ex_br_target(ex_br_target), .ex_pc_next(ex_pc_next), .mem_busy(mem_busy),
    .pc_en(pc_en), .if2id_en(if2id_en), .id2rr_en(id2rr_en), .rr2ex_en(rr2ex_en),
    .ex2mem_en(ex2mem_en), .mem2wb_en(mem2wb_en),
    .if2id_flush(if2id_flush), .id2rr_flush(id2rr_flush), .rr2ex_flush(rr2ex_flush),
    .redir_vld(redir_vld), .redir_pc(redir_pc)
`ifdef HAZ_PERF_CNT_EN
    , .cnt_clr(cnt_clr), .cnt_lu(cnt_lu), .cnt_mispred(cnt_mispred), .cnt_memw(cnt_memw)
`endif
  );
  // {pc, if2id, id2rr, rr2ex, ex2mem, mem2wb enables, if2id, id2rr, rr2ex flushes, redir_vld}
  localparam logic [9:0] NORM = 10'b111111_000_0;
  localparam logic [9:0] FRZ  = 10'b000000_000_0;
  localparam logic [9:0] STL  = 10'b000111_001_0;
  localparam logic [9:0] RED  = 10'b111111_111_1;
  typedef struct {
    logic rst, mb, wr, ld, sav, sbv, bv, tk, sp;
    logic [2:0] dst, sa, sb;
    logic [15:0] tgt, npc;
    logic [9:0] ec;
    logic [15:0] epc;
  } vec_t;
  typedef struct {
    logic [9:0] ec;
    logic [15:0] epc;
  } exp_t;
  vec_t vecs[$];
  string names[$];
  exp_t sb_q[$];
  string sb_names[$];
  int checks = 0, errors = 0;
  task automatic add(input string nm, input logic r, mb, wr, ld, input logic [2:0] dst, sa, input logic sav,
                     input logic [2:0] sb, input logic sbv, input logic bv, tk, sp, input logic [15:0] tgt, npc,
                     input logic [9:0] ec, input logic [15:0] epc);
    vec_t v;
    v.rst = r; v.mb = mb; v.wr = wr; v.ld = ld; v.dst = dst; v.sa = sa; v.sav = sav; v.sb = sb; v.sbv = sbv;
    v.bv = bv; v.tk = tk; v.sp = sp; v.tgt = tgt; v.npc = npc; v.ec = ec; v.epc = epc;
    vecs.push_back(v);
    names.push_back(nm);
  endtask
  task automatic drive(input vec_t v);
    rst = v.rst; mem_busy = v.mb; ex_wr_en = v.wr; ex_is_load = v.ld; ex_dst = v.dst;
    rr_src_a = v.sa; rr_src_a_vld = v.sav; rr_src_b = v.sb; rr_src_b_vld = v.sbv;
    ex_br_vld = v.bv; ex_br_taken = v.tk; ex_spec_taken = v.sp; ex_br_target = v.tgt; ex_pc_next = v.npc;
  endtask
  task automatic check_out();
    exp_t e;
    string nm;
    logic [9:0] act;
    e = sb_q.pop_front();
    nm = sb_names.pop_front();
    act = {pc_en, if2id_en, id2rr_en, rr2ex_en, ex2mem_en, mem2wb_en, if2id_flush, id2rr_flush, rr2ex_flush, redir_vld};
    checks++;
    if (act !== e.ec || redir_pc !== e.epc) begin
      errors++;
      $display("FAIL %s: ctl=%b redir_pc=%h, expected ctl=%b redir_pc=%h", nm, act, redir_pc, e.ec, e.epc);
    end
  endtask
  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    drive(v);
    e.ec = v.ec; e.epc = v.epc;
    sb_q.push_back(e);
    sb_names.push_back(nm);
    #1 check_out();
  endtask
  task automatic chk16(input string nm, input logic [15:0] act, exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask
  initial begin
    //   name          rst mb wr ld dst sa sav sb sbv bv tk sp tgt      npc      exp   pc
    add("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    add("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    add("lu_src_b",     0, 0, 1, 1, 3, 0, 0, 3, 1, 0, 0, 0, 16'h0,   16'h0,   STL,  16'h0);
    add("lu_bubble",    0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    add("lu_novld",     0, 0, 1, 1, 3, 3, 0, 3, 0, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    add("lu_nowr",      0, 0, 0, 1, 3, 3, 1, 0, 0, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    add("lu_src_a",     0, 0, 1, 1, 5, 5, 1, 0, 0, 0, 0, 0, 16'h0,   16'h0,   STL,  16'h0);
    add("alu_no_lu",    0, 0, 1, 0, 5, 5, 1, 0, 0, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    add("mispred_tk",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0040, 16'h0011, RED, 16'h0040);
    add("after_redir",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    add("pred_ok",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h0050, 16'h0012, NORM, 16'h0);
    add("br_novld",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0050, 16'h0012, NORM, 16'h0);
    add("mispred_lu",   0, 0, 1, 1, 2, 2, 1, 0, 0, 1, 0, 1, 16'h0060, 16'h0022, RED, 16'h0022);
    add("mw_frz0",      0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   16'h0,   FRZ,  16'h0);
    add("mw_frz1",      0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   16'h0,   FRZ,  16'h0);
    add("mw_release",   0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 16'h0077, 16'h0030, STL, 16'h0);
    add("mw_idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    add("pend_frz0",    0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0044, 16'h0013, FRZ, 16'h0);
    add("pend_frz1",    0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0044, 16'h0013, FRZ, 16'h0);
    add("pend_frz2",    0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0044, 16'h0013, FRZ, 16'h0);
    add("pend_redir",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0099, 16'h0088, RED, 16'h0013);
    add("pend_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    add("pend_enter",   0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h1234, 16'h0001, FRZ, 16'h0);
    add("rst_in_pend",  1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h1234, 16'h0001, NORM, 16'h0);
    add("post_rst",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    add("busy_over_lu", 0, 1, 1, 1, 4, 4, 1, 0, 0, 0, 0, 0, 16'h0,   16'h0,   FRZ,  16'h0);
    add("busy_lu_rel",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    add("rst_mispred",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0055, 16'h0002, NORM, 16'h0);
    add("rst_release",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   16'h0,   NORM, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < k; j++)
        add("seq_frz", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0100 + 16'(k), 16'h0200, FRZ, 16'h0);
      add("seq_redir", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0300, 16'h0400, RED, 16'h0100 + 16'(k));
      add("seq_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, NORM, 16'h0);
    end
    foreach (vecs[i]) apply(vecs[i], names[i]);
`ifdef HAZ_PERF_CNT_EN
    @(negedge clk);
    drive(vecs[1]);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk16("cnt_lu_clr", cnt_lu, 16'h0);
    chk16("cnt_mispred_clr", cnt_mispred, 16'h0);
    chk16("cnt_memw_clr", cnt_memw, 16'h0);
    drive(vecs[2]);
    @(negedge clk);
    drive(vecs[8]);
    @(negedge clk);
    drive(vecs[1]);
    #1;
    chk16("cnt_lu_one", cnt_lu, 16'h1);
    chk16("cnt_mispred_one", cnt_mispred, 16'h1);
    chk16("cnt_memw_zero", cnt_memw, 16'h0);
    mem_busy = 1'b1;
    repeat (70000) @(negedge clk);
    #1;
    chk16("cnt_memw_sat", cnt_memw, 16'hFFFF);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    mem_busy = 1'b0;
    #1;
    chk16("cnt_memw_clr_prio", cnt_memw, 16'h0);
`endif
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 6-stage pipeline (IF, ID, RR, EX, MEM, WB).
- Drives the enable and bubble/flush controls that the stage pipeline registers (IF2ID, ID2RR, RR2EX, EX2MEM, MEM2WB) consume.
- Resolves three hazard types: load-use, branch misprediction against the speculative-taken bit carried into EX, and data-memory busy.
- Issues the PC redirect on a misprediction.

Parameters:
- DW, 16, data/PC width
- AW, 3, register address width

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous reset, active-high
- rr_src_a  in  AW  RR-stage source register A
- rr_src_a_vld  in  1  RR instruction reads src A
- rr_src_b  in  AW  RR-stage source register B
- rr_src_b_vld  in  1  RR instruction reads src B
- ex_dst  in  AW  EX-stage destination register
- ex_wr_en  in  1  EX instruction writes RF
- ex_is_load  in  1  EX instruction is a load
- ex_br_vld  in  1  EX holds a resolved branch/jump this cycle
- ex_br_taken  in  1  actual branch outcome
- ex_spec_taken  in  1  speculative-taken bit from RR2EX
- ex_br_target  in  DW  taken target
- ex_pc_next  in  DW  fall-through PC
- mem_busy  in  1  data memory not ready; MEM stage cannot advance
- pc_en  out  1  PC register load enable
- if2id_en, id2rr_en, rr2ex_en, ex2mem_en, mem2wb_en  out  1 each  stage register load enables
- if2id_flush, id2rr_flush, rr2ex_flush  out  1 each  load bubble (all-zero) instead of data; overrides the enable
- redir_vld  out  1  PC redirect this cycle
- redir_pc  out  DW  redirect target

Behaviour:
- State register holds one of three states: RUN, MEM_WAIT, MEM_WAIT_PEND. It also holds pend_pc[DW].
- Outputs are combinational from state and inputs.
- mispred = ex_br_vld & (ex_br_taken != ex_spec_taken).
- tgt = ex_br_taken ? ex_br_target : ex_pc_next.
- lu_haz = ex_is_load & ex_wr_en & ((rr_src_a_vld & rr_src_a==ex_dst) | (rr_src_b_vld & rr_src_b==ex_dst)).
- rst high (any state, including mid-stall):
  - Next state is RUN; pend_pc is 0.
  - While rst is high, all enables are 1, all flushes 0, redir_vld 0, redir_pc 0.
- Priority within a cycle: mem_busy > mispred > lu_haz.
- RUN, mem_busy=1:
  - All enables 0 (full freeze); flushes 0.
  - If mispred, capture pend_pc<=tgt and go to MEM_WAIT_PEND; otherwise go to MEM_WAIT.
- RUN, mem_busy=0, mispred=1:
  - All enables 1; if2id/id2rr/rr2ex_flush=1.
  - redir_vld=1, redir_pc=tgt.
  - lu_haz is ignored, since the younger instruction is squashed.
- RUN, mem_busy=0, mispred=0, lu_haz=1:
  - pc_en, if2id_en, id2rr_en = 0 (hold).
  - rr2ex_flush=1 (bubble into EX); ex2mem_en, mem2wb_en = 1.
  - Exactly one stall cycle: the next cycle EX holds the bubble, so lu_haz clears.
- RUN, otherwise: all enables 1, flushes 0.
- MEM_WAIT:
  - Freeze as above while mem_busy=1.
  - When mem_busy=0, return to RUN and evaluate that cycle as RUN. Branch inputs are stale-held and no longer resolving, so ex_br_vld is ignored in this cycle.
- MEM_WAIT_PEND:
  - Freeze while mem_busy=1.
  - On the first cycle with mem_busy=0: all enables 1, the three flushes 1, redir_vld=1, redir_pc=pend_pc; next state RUN.
  - ex_br_vld is ignored in that cycle because the branch was already consumed.
- redir_pc is 0 whenever redir_vld=0.
- A mispredict with ex_br_taken=0 and ex_spec_taken=1 redirects to ex_pc_next.
- Latency: controls take effect at the same posedge the hazard is presented; the redirect is 0-cycle, except for the deferred case.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds three outputs, each 16-bit and saturating at 0xFFFF:
  - cnt_lu: counts load-use stall cycles.
  - cnt_mispred: counts redirects, including deferred ones.
  - cnt_memw: counts frozen cycles.
- Adds input cnt_clr, which zeroes all three counters synchronously; cnt_clr takes priority over increment.
- Counters reset to 0 on rst.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared pipeline package holds the state encoding (RUN=2'd0, MEM_WAIT=2'd1, MEM_WAIT_PEND=2'd2), DW/AW constants, and a bubble value of 0.
- Sub-module hazard_perf_cnt: one saturating counter with clear, instantiated three times under the macro.

Test Plan:
- rst=1 mid MEM_WAIT_PEND with mem_busy=1 → next cycle state RUN, all enables 1, redir_vld=0, pend_pc=0.
- EX load to r3, RR reads r3 on src B → one cycle with pc_en=if2id_en=id2rr_en=0 and rr2ex_flush=1; next cycle all enables 1.
- ex_br_vld=1, taken=1, spec=0, target=0x0040 → redir_vld=1, redir_pc=0x0040, three flushes 1, for exactly one cycle.
- Mispredict (taken=0, spec=1, pc_next=0x0013) with mem_busy=1 for 3 cycles → 3 cycles with all enables 0; then one cycle with redir_vld=1, redir_pc=0x0013, and ex_br_vld ignored.
- Simultaneous mispredict and lu_haz, mem_busy=0 → redirect and flushes only; no hold of pc_en.
- HAZ_PERF_CNT_EN: 70000 frozen cycles → cnt_memw=0xFFFF; cnt_clr=1 → 0 next cycle.
